// File: rtl/key_conditioner.sv
// Pushbutton conditioner: two-flop synchronizer, counter debounce, press/release pulses and
// hold-to-auto-repeat step pulses for one active-low key.
module key_conditioner #(
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned DEBOUNCE      = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic repeat_en,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam logic [CNT_W-1:0] DbLast     = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] TimerOne   = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StDbPress,
    StHeld,
    StRepeat,
    StDbRelease
  } state_e;

  logic             meta_n_q, sync_n_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;

  // Both flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_n_q <= 1'b1;
      sync_n_q <= 1'b1;
    end else begin
      meta_n_q <= key_n;
      sync_n_q <= meta_n_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;
    case (state_q)
      StIdle: begin
        pressed_d = 1'b0;
        if (!sync_n_q) begin
          state_d = StDbPress;
          timer_d = TimerOne;
        end
      end
      StDbPress: begin
        if (sync_n_q) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q == DbLast) begin
          state_d   = StHeld;
          timer_d   = '0;
          press_d   = 1'b1;
          step_d    = 1'b1;
          pressed_d = 1'b1;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StHeld: begin
        pressed_d = 1'b1;
        if (sync_n_q) begin
          state_d = StDbRelease;
          timer_d = TimerOne;
        end else if (!repeat_en) begin
          timer_d = '0;
        end else if (timer_q == DelayLast) begin
          state_d = StRepeat;
          timer_d = '0;
          step_d  = 1'b1;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StRepeat: begin
        pressed_d = 1'b1;
        // Release outranks a repeat that would fire on the same edge.
        if (sync_n_q) begin
          state_d = StDbRelease;
          timer_d = TimerOne;
        end else if (!repeat_en) begin
          state_d = StHeld;
          timer_d = '0;
        end else if (timer_q == PeriodLast) begin
          timer_d = '0;
          step_d  = 1'b1;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StDbRelease: begin
        pressed_d = 1'b1;
        if (!sync_n_q) begin
          state_d = StHeld;
          timer_d = '0;
        end else if (timer_q == DbLast) begin
          state_d   = StIdle;
          timer_d   = '0;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      default: begin
        state_d   = StIdle;
        timer_d   = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: expected pulse cycles are queued when the key is driven
// and matched against the cycle each DUT pulse appears in.
module tb_key_conditioner;

  localparam int unsigned CntW         = 8;
  localparam int unsigned Debounce     = 4;
  localparam int unsigned RepeatDelay  = 10;
  localparam int unsigned RepeatPeriod = 3;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic repeat_en;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic step_pulse;

  key_conditioner #(
    .CNT_W        (CntW),
    .DEBOUNCE     (Debounce),
    .REPEAT_DELAY (RepeatDelay),
    .REPEAT_PERIOD(RepeatPeriod)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .repeat_en    (repeat_en),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse)
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; cycle c of a test is sampled when cyc == t0 + c.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int press_q[$];
  int release_q[$];
  int step_q[$];

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < t) check_val("wait_timeout", cyc, t);
  endtask

  task automatic check_drained(input string tag);
    check_val({tag, "_press_left"}, press_q.size(), 0);
    check_val({tag, "_release_left"}, release_q.size(), 0);
    check_val({tag, "_step_left"}, step_q.size(), 0);
  endtask

  task automatic push_repeats(input int t0, input int last);
    step_q.push_back(t0 + 6);
    for (int c = 6 + RepeatDelay + 1; c <= last; c += RepeatPeriod + 1) step_q.push_back(t0 + c);
  endtask

  always @(negedge clk) begin
    if (press_pulse === 1'b1) begin
      if (press_q.size() == 0) check_val("press_extra", cyc, -1);
      else check_val("press_at", cyc, press_q.pop_front());
    end
    if (release_pulse === 1'b1) begin
      if (release_q.size() == 0) check_val("release_extra", cyc, -1);
      else check_val("release_at", cyc, release_q.pop_front());
    end
    if (step_pulse === 1'b1) begin
      if (step_q.size() == 0) check_val("step_extra", cyc, -1);
      else check_val("step_at", cyc, step_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    reset     = 1'b1;
    key_n     = 1'b1;
    repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_outputs", int'({pressed, press_pulse, release_pulse, step_pulse}), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press, no repeat.
    repeat_en = 1'b0;
    key_n = 1'b0;
    t0 = cyc + 1;
    press_q.push_back(t0 + 6);
    step_q.push_back(t0 + 6);
    release_q.push_back(t0 + 46);
    wait_until(t0 + 5);  check_val("t1_pressed_c5", int'(pressed), 0);
    wait_until(t0 + 6);  check_val("t1_pressed_c6", int'(pressed), 1);
    wait_until(t0 + 39); key_n = 1'b1;
    wait_until(t0 + 45); check_val("t1_pressed_c45", int'(pressed), 1);
    wait_until(t0 + 46); check_val("t1_pressed_c46", int'(pressed), 0);
    wait_until(t0 + 55); check_drained("t1");

    // Bounce: no low run long enough to be accepted.
    key_n = 1'b0;
    t0 = cyc + 1;
    wait_until(t0 + 2); key_n = 1'b1;
    wait_until(t0 + 4); key_n = 1'b0;
    wait_until(t0 + 6); key_n = 1'b1;
    wait_until(t0 + 9);  check_val("t2_pressed_c9", int'(pressed), 0);
    wait_until(t0 + 20); check_val("t2_pressed_c20", int'(pressed), 0);
    check_drained("t2");

    // Auto-repeat while held.
    repeat_en = 1'b1;
    key_n = 1'b0;
    t0 = cyc + 1;
    press_q.push_back(t0 + 6);
    push_repeats(t0, 45);
    release_q.push_back(t0 + 50);
    wait_until(t0 + 43); key_n = 1'b1;
    wait_until(t0 + 49); check_val("t3_pressed_c49", int'(pressed), 1);
    wait_until(t0 + 50); check_val("t3_pressed_c50", int'(pressed), 0);
    wait_until(t0 + 60); check_drained("t3");

    // Two-cycle release glitch while held restarts the repeat delay.
    key_n = 1'b0;
    t0 = cyc + 1;
    press_q.push_back(t0 + 6);
    step_q.push_back(t0 + 6);
    step_q.push_back(t0 + 23);
    release_q.push_back(t0 + 30);
    wait_until(t0 + 7);  key_n = 1'b1;
    wait_until(t0 + 9);  key_n = 1'b0;
    wait_until(t0 + 11); check_val("t4_pressed_c11", int'(pressed), 1);
    wait_until(t0 + 13); check_val("t4_pressed_c13", int'(pressed), 1);
    wait_until(t0 + 23); key_n = 1'b1;
    wait_until(t0 + 29); check_val("t4_pressed_c29", int'(pressed), 1);
    wait_until(t0 + 30); check_val("t4_pressed_c30", int'(pressed), 0);
    wait_until(t0 + 40); check_drained("t4");

    // Release lands on the edge a repeat would fire.
    key_n = 1'b0;
    t0 = cyc + 1;
    press_q.push_back(t0 + 6);
    push_repeats(t0, 45);
    release_q.push_back(t0 + 53);
    wait_until(t0 + 46); key_n = 1'b1;
    wait_until(t0 + 49);
    check_val("t6_step_c49", int'(step_pulse), 0);
    check_val("t6_pressed_c49", int'(pressed), 1);
    wait_until(t0 + 53); check_val("t6_pressed_c53", int'(pressed), 0);
    wait_until(t0 + 62); check_drained("t6");

    // Reset mid-debounce, then again right on a repeat pulse.
    repeat_en = 1'b1;
    key_n = 1'b0;
    t0 = cyc + 1;
    wait_until(t0 + 3);
    #2 reset = 1'b1;
    #1 check_val("t5_rst_db", int'({pressed, press_pulse, release_pulse, step_pulse}), 0);
    press_q.delete(); release_q.delete(); step_q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    t0 = cyc + 1;
    press_q.push_back(t0 + 6);
    push_repeats(t0, 21);
    wait_until(t0 + 21);
    #2 reset = 1'b1;
    #1 check_val("t5_rst_rep", int'({pressed, press_pulse, release_pulse, step_pulse}), 0);
    press_q.delete(); release_q.delete(); step_q.delete();
    repeat_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    t0 = cyc + 1;
    press_q.push_back(t0 + 6);
    step_q.push_back(t0 + 6);
    release_q.push_back(t0 + 16);
    wait_until(t0 + 9);  key_n = 1'b1;
    wait_until(t0 + 15); check_val("t5_pressed_c15", int'(pressed), 1);
    wait_until(t0 + 25); check_drained("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
